scroll_camera: RTL and testbench

Parametrised horizontal camera controller for the multi-player level renderer. Once per frame it scans every active player's world X position, decides whether the viewport must scroll left, scroll right, or hold, and moves the camera origin by a bounded step. It also produces per-player leash flags, so the movement logic cannot push two players apart past the visible screen. It sits between the player motion blocks and the sprite/background drawing logic, which subtract `cam_x` from world coordinates.

---
 rtl/scroll_camera.sv | 257 +++++++++++++++++++++++++
 tb/tb_scroll_camera.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/scroll_camera.sv
// Horizontal camera controller: scans player positions once per frame, scrolls the
// viewport by a bounded step and raises per-player leash flags.
module scroll_camera #(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 12,
    parameter int LEFT_EDGE   = 160,
    parameter int RIGHT_EDGE  = 480,
    parameter int LEFT_MAX    = 20,
    parameter int RIGHT_MAX   = 620,
    parameter int WORLD_MAX   = 1920,
    parameter int MAX_STEP    = 4
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
    input  logic                           frame_tick,
    input  logic                           level_restart,
    input  logic [NUM_PLAYERS*COORD_W-1:0] player_x,
    input  logic [NUM_PLAYERS-1:0]         player_active,
    output logic [COORD_W-1:0]             cam_x,
    output logic                           busy,
    output logic [1:0]                     scroll_dir,
    output logic [NUM_PLAYERS-1:0]         block_right,
    output logic [NUM_PLAYERS-1:0]         block_left,
    output logic                           overrun
);

    localparam int AW = COORD_W + 1;
    localparam int IW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

    localparam logic [AW-1:0] LE_C = AW'(LEFT_EDGE);
    localparam logic [AW-1:0] RE_C = AW'(RIGHT_EDGE);
    localparam logic [AW-1:0] LM_C = AW'(LEFT_MAX);
    localparam logic [AW-1:0] RM_C = AW'(RIGHT_MAX);
    localparam logic [AW-1:0] WM_C = AW'(WORLD_MAX);
    localparam logic [AW-1:0] MS_C = AW'(MAX_STEP);

    localparam logic [1:0] DIR_HOLD  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DECIDE = 2'd2,
        STEP   = 2'd3
    } state_t;

    function automatic logic [AW-1:0] min2(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    state_t                   state_q;
    logic [IW-1:0]            idx_q;
    logic [COORD_W-1:0]       min_rel_q;
    logic [COORD_W-1:0]       max_rel_q;
    logic                     any_act_q;
    logic [COORD_W-1:0]       rel_q [NUM_PLAYERS];
    logic [AW-1:0]            step_q;
    logic [1:0]               dir_pend_q;
    logic [COORD_W-1:0]       cam_q;
    logic                     busy_q;
    logic [1:0]               scroll_dir_q;
    logic [NUM_PLAYERS-1:0]   block_right_q;
    logic [NUM_PLAYERS-1:0]   block_left_q;
    logic                     overrun_q;

    logic [COORD_W-1:0]       cur_x_s;
    logic                     cur_act_s;
    logic [COORD_W-1:0]       rel_s;
    logic [AW-1:0]            min_w_s;
    logic [AW-1:0]            max_w_s;
    logic [AW-1:0]            cam_w_s;
    logic [AW-1:0]            step_d;
    logic [1:0]               dir_d;
    logic [AW-1:0]            cam_up_s;
    logic [AW-1:0]            cam_dn_s;
    logic [NUM_PLAYERS-1:0]   lo_s;
    logic [NUM_PLAYERS-1:0]   hi_s;
    logic [NUM_PLAYERS-1:0]   others_s;
    logic [NUM_PLAYERS-1:0]   block_right_d;
    logic [NUM_PLAYERS-1:0]   block_left_d;

    // Select the player under scan and compute its screen-relative X (clamped at 0).
    always_comb begin
        cur_x_s   = '0;
        cur_act_s = 1'b0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_x_s   = player_x[i*COORD_W +: COORD_W];
                cur_act_s = player_active[i];
            end else begin
                cur_x_s   = cur_x_s;
                cur_act_s = cur_act_s;
            end
        end
        if (cur_x_s >= cam_q) begin
            rel_s = cur_x_s - cam_q;
        end else begin
            rel_s = '0;
        end
    end

    // Scroll decision on widened operands so differences cannot wrap.
    always_comb begin
        min_w_s  = {1'b0, min_rel_q};
        max_w_s  = {1'b0, max_rel_q};
        cam_w_s  = {1'b0, cam_q};
        cam_up_s = cam_w_s + step_q;
        cam_dn_s = cam_w_s - step_q;
        step_d   = '0;
        dir_d    = DIR_HOLD;
        if (!any_act_q) begin
            step_d = '0;
            dir_d  = DIR_HOLD;
        end else if ((max_w_s > RE_C) && (min_w_s > LE_C)) begin
            step_d = min2(min2(MS_C, max_w_s - RE_C), min2(min_w_s - LE_C, WM_C - cam_w_s));
            dir_d  = (step_d == '0) ? DIR_HOLD : DIR_RIGHT;
        end else if ((min_w_s < LE_C) && (max_w_s < RE_C)) begin
            step_d = min2(min2(MS_C, LE_C - min_w_s), min2(RE_C - max_w_s, cam_w_s));
            dir_d  = (step_d == '0) ? DIR_HOLD : DIR_LEFT;
        end else begin
            step_d = '0;
            dir_d  = DIR_HOLD;
        end
    end

    // Leash: a player at one screen edge is blocked while another active player hugs the other edge.
    always_comb begin
        lo_s          = '0;
        hi_s          = '0;
        others_s      = '0;
        block_right_d = '0;
        block_left_d  = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            lo_s[i] = player_active[i] && ({1'b0, rel_q[i]} <= LM_C);
            hi_s[i] = player_active[i] && ({1'b0, rel_q[i]} >= RM_C);
        end
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            others_s         = lo_s;
            others_s[i]      = 1'b0;
            block_right_d[i] = hi_s[i] && (|others_s);
            others_s         = hi_s;
            others_s[i]      = 1'b0;
            block_left_d[i]  = lo_s[i] && (|others_s);
        end
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            min_rel_q     <= '1;
            max_rel_q     <= '0;
            any_act_q     <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                rel_q[i] <= '0;
            end
            step_q        <= '0;
            dir_pend_q    <= DIR_HOLD;
            cam_q         <= '0;
            busy_q        <= 1'b0;
            scroll_dir_q  <= DIR_HOLD;
            block_right_q <= '0;
            block_left_q  <= '0;
            overrun_q     <= 1'b0;
        end else begin
            if (frame_tick && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else begin
                overrun_q <= overrun_q;
            end
            if (level_restart) begin
                state_q       <= IDLE;
                cam_q         <= '0;
                busy_q        <= 1'b0;
                scroll_dir_q  <= DIR_HOLD;
                block_right_q <= '0;
                block_left_q  <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (frame_tick) begin
                            idx_q     <= '0;
                            min_rel_q <= '1;
                            max_rel_q <= '0;
                            any_act_q <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= SCAN;
                        end else begin
                            state_q   <= IDLE;
                        end
                    end
                    SCAN: begin
                        for (int i = 0; i < NUM_PLAYERS; i++) begin
                            if (idx_q == IW'(i)) begin
                                rel_q[i] <= rel_s;
                            end else begin
                                rel_q[i] <= rel_q[i];
                            end
                        end
                        if (cur_act_s) begin
                            any_act_q <= 1'b1;
                            if (rel_s < min_rel_q) begin
                                min_rel_q <= rel_s;
                            end else begin
                                min_rel_q <= min_rel_q;
                            end
                            if (rel_s > max_rel_q) begin
                                max_rel_q <= rel_s;
                            end else begin
                                max_rel_q <= max_rel_q;
                            end
                        end else begin
                            any_act_q <= any_act_q;
                        end
                        if (idx_q == IW'(NUM_PLAYERS - 1)) begin
                            state_q <= DECIDE;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                        end
                    end
                    DECIDE: begin
                        step_q        <= step_d;
                        dir_pend_q    <= dir_d;
                        block_right_q <= block_right_d;
                        block_left_q  <= block_left_d;
                        state_q       <= STEP;
                    end
                    STEP: begin
                        // Saturating updates keep cam_x inside [0, WORLD_MAX] even if step were corrupted.
                        case (dir_pend_q)
                            DIR_RIGHT: cam_q <= (cam_up_s > WM_C) ? WM_C[COORD_W-1:0] : cam_up_s[COORD_W-1:0];
                            DIR_LEFT:  cam_q <= cam_dn_s[AW-1] ? '0 : cam_dn_s[COORD_W-1:0];
                            default:   cam_q <= cam_q;
                        endcase
                        scroll_dir_q <= dir_pend_q;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cam_x       = cam_q;
    assign busy        = busy_q;
    assign scroll_dir  = scroll_dir_q;
    assign block_right = block_right_q;
    assign block_left  = block_left_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_scroll_camera.sv
// Directed self-checking bench for scroll_camera with the default parameters.
module tb_scroll_camera;

    logic        Clk;
    logic        Reset_n;
    logic        frame_tick;
    logic        level_restart;
    logic [23:0] player_x;
    logic [1:0]  player_active;
    logic [11:0] cam_x;
    logic        busy;
    logic [1:0]  scroll_dir;
    logic [1:0]  block_right;
    logic [1:0]  block_left;
    logic        overrun;

    int n_checks;
    int n_fail;
    int bcnt;
    int cam_e;

    scroll_camera dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_tick    (frame_tick),
        .level_restart (level_restart),
        .player_x      (player_x),
        .player_active (player_active),
        .cam_x         (cam_x),
        .busy          (busy),
        .scroll_dir    (scroll_dir),
        .block_right   (block_right),
        .block_left    (block_left),
        .overrun       (overrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on a negedge with the DUT back in IDLE.
    task automatic run_frame(input logic [11:0] x0, input logic [11:0] x1,
                             input logic [1:0] act, output int cnt);
        player_x      = {x1, x0};
        player_active = act;
        frame_tick    = 1'b1;
        @(negedge Clk);
        frame_tick    = 1'b0;
        cnt = 0;
        while (busy && cnt < 20) begin
            cnt++;
            @(negedge Clk);
        end
        if (cnt >= 20) check_eq("frame_timeout", 32'(cnt), 32'd4);
        @(negedge Clk);
    endtask

    task automatic pulse_restart();
        level_restart = 1'b1;
        @(negedge Clk);
        level_restart = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        Reset_n       = 1'b0;
        frame_tick    = 1'b0;
        level_restart = 1'b0;
        player_x      = 24'd0;
        player_active = 2'b00;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        check_eq("rst_cam", 32'(cam_x), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_dir", 32'(scroll_dir), 32'd0);
        check_eq("rst_br", 32'(block_right), 32'd0);
        check_eq("rst_bl", 32'(block_left), 32'd0);
        check_eq("rst_ovr", 32'(overrun), 32'd0);

        // Both at 300: hold, busy for NUM_PLAYERS+2 cycles
        run_frame(12'd300, 12'd300, 2'b11, bcnt);
        check_eq("hold_busy_cycles", 32'(bcnt), 32'd4);
        check_eq("hold_cam", 32'(cam_x), 32'd0);
        check_eq("hold_dir", 32'(scroll_dir), 32'd0);

        // Players 500/200: right by 4 per frame until cam 20
        cam_e = 0;
        for (int k = 0; k < 5; k++) begin
            run_frame(12'd500, 12'd200, 2'b11, bcnt);
            cam_e += 4;
            check_eq("right_cam", 32'(cam_x), 32'(cam_e));
            check_eq("right_dir", 32'(scroll_dir), 32'd1);
        end
        run_frame(12'd500, 12'd200, 2'b11, bcnt);
        check_eq("right_stop_cam", 32'(cam_x), 32'd20);
        check_eq("right_stop_dir", 32'(scroll_dir), 32'd0);

        // Walk right to 100 with rel 600/300
        for (int k = 0; k < 20; k++) begin
            run_frame(12'(cam_e + 600), 12'(cam_e + 300), 2'b11, bcnt);
            cam_e += 4;
        end
        check_eq("walk_to_100", 32'(cam_x), 32'd100);

        // Players 150/200 at cam 100: left to 0, then hold without underflow
        run_frame(12'd150, 12'd200, 2'b11, bcnt);
        check_eq("left_cam", 32'(cam_x), 32'd96);
        check_eq("left_dir", 32'(scroll_dir), 32'd2);
        for (int k = 0; k < 24; k++) run_frame(12'd150, 12'd200, 2'b11, bcnt);
        check_eq("left_to_0", 32'(cam_x), 32'd0);
        check_eq("left_to_0_dir", 32'(scroll_dir), 32'd2);
        run_frame(12'd150, 12'd200, 2'b11, bcnt);
        check_eq("left_floor_cam", 32'(cam_x), 32'd0);
        check_eq("left_floor_dir", 32'(scroll_dir), 32'd0);

        // Walk right to 1916, then step 2 to 1918, then 2 to 1920, then hold
        cam_e = 0;
        for (int k = 0; k < 479; k++) begin
            run_frame(12'(cam_e + 600), 12'(cam_e + 300), 2'b11, bcnt);
            cam_e += 4;
        end
        check_eq("walk_to_1916", 32'(cam_x), 32'd1916);
        run_frame(12'd2398, 12'd2216, 2'b11, bcnt);
        check_eq("edge_1918", 32'(cam_x), 32'd1918);
        run_frame(12'd2518, 12'd2218, 2'b11, bcnt);
        check_eq("edge_1920", 32'(cam_x), 32'd1920);
        check_eq("edge_1920_dir", 32'(scroll_dir), 32'd1);
        run_frame(12'd2520, 12'd2220, 2'b11, bcnt);
        check_eq("world_max_cam", 32'(cam_x), 32'd1920);
        check_eq("world_max_dir", 32'(scroll_dir), 32'd0);

        // Leash at cam 0: players 630 and 10
        pulse_restart();
        check_eq("restart_cam", 32'(cam_x), 32'd0);
        run_frame(12'd630, 12'd10, 2'b11, bcnt);
        check_eq("leash_br", 32'(block_right), 32'd1);
        check_eq("leash_bl", 32'(block_left), 32'd2);
        check_eq("leash_dir", 32'(scroll_dir), 32'd0);
        check_eq("leash_cam", 32'(cam_x), 32'd0);
        pulse_restart();
        check_eq("restart_br", 32'(block_right), 32'd0);
        check_eq("restart_bl", 32'(block_left), 32'd0);
        // Only player 0 (rel 630) active: no leash, scroll right by 4
        run_frame(12'd630, 12'd10, 2'b01, bcnt);
        check_eq("solo_br", 32'(block_right), 32'd0);
        check_eq("solo_bl", 32'(block_left), 32'd0);
        check_eq("solo_cam", 32'(cam_x), 32'd4);
        check_eq("solo_dir", 32'(scroll_dir), 32'd1);

        // Back-to-back ticks: overrun, single update
        pulse_restart();
        check_eq("pre_ovr", 32'(overrun), 32'd0);
        player_x      = {12'd200, 12'd500};
        player_active = 2'b11;
        frame_tick    = 1'b1;
        @(negedge Clk);
        frame_tick    = 1'b0;
        @(negedge Clk);
        frame_tick    = 1'b1;
        @(negedge Clk);
        frame_tick    = 1'b0;
        repeat (10) @(negedge Clk);
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        check_eq("ovr_single_cam", 32'(cam_x), 32'd4);
        check_eq("ovr_busy", 32'(busy), 32'd0);

        // Restart mid-SCAN
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        check_eq("scan_busy", 32'(busy), 32'd1);
        level_restart = 1'b1;
        @(negedge Clk);
        level_restart = 1'b0;
        check_eq("mid_restart_busy", 32'(busy), 32'd0);
        check_eq("mid_restart_cam", 32'(cam_x), 32'd0);
        check_eq("mid_restart_ovr", 32'(overrun), 32'd1);
        repeat (6) @(negedge Clk);
        check_eq("mid_restart_cam_hold", 32'(cam_x), 32'd0);

        // Asynchronous reset clears overrun before any clock edge
        Reset_n = 1'b0;
        #1;
        check_eq("async_rst_ovr", 32'(overrun), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
